// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared encodings for the memory-access stage.
// Revision : 1.0
// ============================================================================
package mem_pkg;

    localparam int c_OP_LB  = 0;
    localparam int c_OP_LH  = 1;
    localparam int c_OP_LW  = 2;
    localparam int c_OP_LBU = 3;
    localparam int c_OP_LHU = 4;
    localparam int c_OP_SB  = 5;
    localparam int c_OP_SH  = 6;
    localparam int c_OP_SW  = 7;

    localparam logic [5:0] c_ECODE_ALE = 6'h09;

    localparam logic [1:0] c_SIZE_BYTE = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;
    localparam logic [1:0] c_SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic is_load(input logic [7:0] op);
        return |op[4:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Brief    : Shifts the bus read word down to the accessed lane and extends it.
// Revision : 1.0
// ============================================================================
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [4:0]  load_op,
    output logic [31:0] result
);

    logic [31:0] w_shifted;

    assign w_shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        result = '0;
        if (load_op[c_OP_LB])
            result = {{24{w_shifted[7]}}, w_shifted[7:0]};
        else if (load_op[c_OP_LBU])
            result = {24'h0, w_shifted[7:0]};
        else if (load_op[c_OP_LH])
            result = {{16{w_shifted[15]}}, w_shifted[15:0]};
        else if (load_op[c_OP_LHU])
            result = {16'h0, w_shifted[15:0]};
        else if (load_op[c_OP_LW])
            result = w_shifted;
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Brief    : EXE->WB memory stage on a req/addr_ok/data_ok bus with
//            orphaned-response discard counting across flushes.
// Revision : 1.0
// ============================================================================
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          MAX_DISCARD = 3,
    parameter logic [31:0] RESET_PC    = 32'h1c000000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    input  logic [31:0]       in_pc,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [7:0]        in_mem_op,
    input  logic [31:0]       in_wdata,
    input  logic              in_has_exc,
    input  logic [5:0]        in_ecode,
    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [3:0]        wstrb,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       wdata,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [31:0]       rdata,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_result,
    output logic              out_has_exc,
    output logic [5:0]        out_ecode,
    output logic [ADDR_W-1:0] out_badv
);

    localparam int                DCNT_W     = $clog2(MAX_DISCARD + 1);
    localparam logic [DCNT_W-1:0] c_DCNT_MAX = DCNT_W'(MAX_DISCARD);

    state_t              r_state;
    state_t              w_state_nxt;
    state_t              w_accept_state;
    logic [DCNT_W-1:0]   r_dcnt;
    logic [31:0]         r_pc;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_op;
    logic [31:0]         r_wdata;
    logic [31:0]         r_result;
    logic                r_has_exc;
    logic [5:0]          r_ecode;
    logic [ADDR_W-1:0]   r_badv;

    logic                w_accept;
    logic                w_misaligned;
    logic                w_addr_hs;
    logic                w_own;
    logic                w_dcnt_inc;
    logic                w_dcnt_dec;
    logic [31:0]         w_load_data;

    assign in_ready  = resetn && !flush &&
                       ((r_state == ST_EMPTY) || ((r_state == ST_DONE) && out_ready));
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid && in_ready;

    assign w_misaligned =
        ((in_mem_op[c_OP_LH] || in_mem_op[c_OP_LHU] || in_mem_op[c_OP_SH]) && in_addr[0]) ||
        ((in_mem_op[c_OP_LW] || in_mem_op[c_OP_SW]) && (in_addr[1:0] != 2'b00));

    assign w_accept_state = ((in_mem_op == 8'h00) || in_has_exc || w_misaligned)
                            ? ST_DONE : ST_ISSUE;

    // A saturated counter means the bus may still owe us MAX_DISCARD stale
    // responses; issuing now would make our own response ambiguous.
    assign req       = (r_state == ST_ISSUE) && (r_dcnt != c_DCNT_MAX);
    assign w_addr_hs = req && addr_ok;
    assign w_own     = data_ok && (r_dcnt == '0) && (r_state == ST_WAIT);

    assign w_dcnt_inc = flush && (((r_state == ST_ISSUE) && w_addr_hs) ||
                                  ((r_state == ST_WAIT) && !w_own));
    assign w_dcnt_dec = data_ok && (r_dcnt != '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = w_accept_state;
            ST_ISSUE: begin
                if (flush)          w_state_nxt = ST_EMPTY;
                else if (w_addr_hs) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush)      w_state_nxt = ST_EMPTY;
                else if (w_own) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (flush)          w_state_nxt = ST_EMPTY;
                else if (w_accept)  w_state_nxt = w_accept_state;
                else if (out_ready) w_state_nxt = ST_EMPTY;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_EMPTY;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_dcnt_inc && !w_dcnt_dec)
                r_dcnt <= r_dcnt + 1'b1;
            else if (!w_dcnt_inc && w_dcnt_dec)
                r_dcnt <= r_dcnt - 1'b1;
        end
    end

    load_align u_load_align (
        .rdata   (rdata),
        .addr_lo (r_addr[1:0]),
        .load_op (r_op[4:0]),
        .result  (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pc      <= RESET_PC;
            r_addr    <= '0;
            r_op      <= '0;
            r_wdata   <= '0;
            r_result  <= '0;
            r_has_exc <= 1'b0;
            r_ecode   <= '0;
            r_badv    <= '0;
        end else if (w_accept) begin
            r_pc      <= in_pc;
            r_addr    <= in_addr;
            r_op      <= in_mem_op;
            r_wdata   <= in_wdata;
            r_result  <= 32'(in_addr);
            r_has_exc <= in_has_exc || w_misaligned;
            r_ecode   <= in_has_exc ? in_ecode : (w_misaligned ? c_ECODE_ALE : 6'h00);
            r_badv    <= (!in_has_exc && w_misaligned) ? in_addr : '0;
        end else if (w_own && is_load(r_op)) begin
            r_result  <= w_load_data;
        end
    end

    // Bus fields derive from the held payload, so they stay stable until addr_ok.
    always_comb begin
        size  = c_SIZE_BYTE;
        wstrb = 4'b0000;
        wdata = 32'h0;
        if (r_op[c_OP_SB]) begin
            wstrb = 4'b0001 << r_addr[1:0];
            wdata = {4{r_wdata[7:0]}};
        end else if (r_op[c_OP_SH]) begin
            size  = c_SIZE_HALF;
            wstrb = 4'b0011 << r_addr[1:0];
            wdata = {2{r_wdata[15:0]}};
        end else if (r_op[c_OP_SW]) begin
            size  = c_SIZE_WORD;
            wstrb = 4'b1111;
            wdata = r_wdata;
        end else if (r_op[c_OP_LH] || r_op[c_OP_LHU]) begin
            size  = c_SIZE_HALF;
        end else if (r_op[c_OP_LW]) begin
            size  = c_SIZE_WORD;
        end
    end

    assign wr          = |r_op[7:5];
    assign addr        = r_addr;
    assign out_pc      = r_pc;
    assign out_result  = r_result;
    assign out_has_exc = r_has_exc;
    assign out_ecode   = r_ecode;
    assign out_badv    = r_badv;

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised memory-access pipeline stage between EXE and WB. It issues loads and stores on the request/response (`req`/`addr_ok`/`data_ok`) data bus, so a response may take many cycles. It extracts and extends load data, raises address-alignment exceptions, and absorbs responses to requests orphaned by a pipeline flush using a configurable-depth discard counter.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `MAX_DISCARD`, default 3: maximum number of orphaned responses tracked; counter width is `$clog2(MAX_DISCARD+1)`.
- `RESET_PC`, default 32'h1c000000: reset value of `out_pc`.

Ports:
- `clk` in 1: clock. One clock domain.
- `resetn` in 1: reset. Synchronous, active-low.
- `in_valid` in 1, `in_ready` out 1: upstream handshake.
- `out_valid` out 1, `out_ready` in 1: downstream handshake.
- `flush` in 1: exception or ertn flush from WB.
- `in_pc` in 32: instruction PC.
- `in_addr` in ADDR_W: ALU result, which is the effective address for memory ops.
- `in_mem_op` in 8: one-hot {SW,SH,SB,LHU,LBU,LW,LH,LB} on bits [7:0]; all zero means no memory op.
- `in_wdata` in 32: store source register value.
- `in_has_exc` in 1, `in_ecode` in 6: exception carried from upstream.
- `req` out 1, `wr` out 1, `size` out 2, `wstrb` out 4, `addr` out ADDR_W, `wdata` out 32: bus request.
- `addr_ok` in 1, `data_ok` in 1, `rdata` in 32: bus response. Responses return in issue order.
- `out_pc` out 32: PC passed to WB.
- `out_result` out 32: load data for loads, otherwise `in_addr`.
- `out_has_exc` out 1, `out_ecode` out 6, `out_badv` out ADDR_W: exception passed to WB.

## Operation
- The stage holds one instruction. Its payload is registered when `in_valid && in_ready`.
- FSM states:
  - EMPTY
  - ISSUE: `req`=1 until `addr_ok`.
  - WAIT: waiting for the own `data_ok`.
  - DONE: `out_valid`=1.
- Transitions on accept:
  - Non-memory instruction, incoming exception, or misaligned access goes to DONE.
  - Otherwise goes to ISSUE.
- Misalignment check:
  - LH, LHU, SH: `addr[0]`≠0.
  - LW, SW: `addr[1:0]`≠0.
  - Result: `out_has_exc`=1, `out_ecode`=6'h09 (ALE), `out_badv`=`in_addr`, no bus request.
  - An incoming `in_has_exc` takes priority and keeps its own ecode.
- Bus fields:
  - `size` = 0 for byte, 1 for half, 2 for word.
  - `wr` = store.
  - `addr` = `in_addr` unmasked.
  - `wstrb` = SB `4'b0001<<addr[1:0]`, SH `4'b0011<<addr[1:0]`, SW `4'b1111`; loads 0.
  - `wdata` = byte replicated ×4, half replicated ×2, or the word.
- Load data: `rdata >> (8*addr[1:0])`, then sign-extend (LB/LH) or zero-extend (LBU/LHU), registered on `data_ok`.
- Discard counter `dcnt`:
  - While `dcnt`>0, each `data_ok` decrements `dcnt` and is ignored.
  - A `data_ok` counts as the own response only when `dcnt`==0 and the state is WAIT.
  - ISSUE holds `req`=0 while `dcnt`==MAX_DISCARD.
- Flush (highest priority):
  - ISSUE without `addr_ok` in the same cycle: go to EMPTY, `req` drops next cycle, no count.
  - ISSUE with `addr_ok` in the same cycle, or WAIT without own `data_ok`: `dcnt`+1, go to EMPTY.
  - WAIT with own `data_ok` in the same cycle: go to EMPTY, no count.
  - DONE: `out_valid` drops, go to EMPTY.
  - `in_ready` is forced 0 during the flush cycle.
  - A `data_ok` arriving in the same cycle as an increment nets to no change.

## Timing
- `in_ready` = `resetn && !flush && (EMPTY || (DONE && out_ready))`.
- Non-memory instruction accepted in cycle N: `out_valid`=1 in N+1.
- Memory instruction accepted in cycle N:
  - `req`=1 from N+1 (if `dcnt`<MAX_DISCARD).
  - `addr_ok` in cycle A.
  - Own `data_ok` no earlier than A+1, in cycle D.
  - `out_valid`=1 in D+1.
- `req` and its fields stay stable until `addr_ok`.
- Back-to-back: DONE with `out_ready` and `in_valid` accepts the next instruction in the same cycle.
- Reset values:
  - state EMPTY, `dcnt` 0.
  - `out_valid` 0, `req` 0.
  - `out_pc` RESET_PC.
  - `out_result` 0, `out_has_exc` 0, `out_ecode` 0, `out_badv` 0.
  - Bus fields 0.
- Reset mid-transaction clears `dcnt`. The bus is also reset, so no stale response is expected.

## Structure
- Shared package `mem_pkg`:
  - `mem_op` bit indices.
  - ALE ecode 6'h09.
  - FSM state enum.
  - `size` encodings.
- One sub-module, `load_align`: combinational shift and extension of `rdata`.

## Test plan
- **ALU op:** `in_mem_op`=0, `in_addr`=32'h1234. Required: `out_valid` next cycle, `out_result`=32'h1234, `req` never asserted.
- **LB with delays:** LB `addr`=32'h1c000003, `rdata`=32'h80xxxxxx, `addr_ok` after 2 cycles, `data_ok` after 3 more. Required: `out_result`=32'hffffff80, `size`=0.
- **Store encoding:**
  - SH `addr`=32'h1002, `in_wdata`=32'h0000abcd. Required: `wstrb`=4'b1100, `wdata`=32'habcdabcd.
  - SW `addr`=32'h1001. Required: ALE, `out_badv`=32'h1001, no `req`.
- **Flush in WAIT:** flush in WAIT, then a new LW issued. Required: the first `data_ok` is dropped with `dcnt` 1→0; the second `data_ok` is the LW result.
- **Discard saturation:** three flushes in WAIT with `MAX_DISCARD`=3. Required: `dcnt`=3, the next instruction holds `req`=0 until a `data_ok` arrives.
- **Same-cycle flush and `addr_ok`:** flush in the same cycle as `addr_ok`. Required: `dcnt` increments. Same test with flush and no `addr_ok`: `dcnt` unchanged, `req` low next cycle.
